multi_channel_echo_timer: RTL and testbench

Parametrised, clocked successor to the single-channel send/receive window latch in the wireless sender. For each of `N_CH` channels it:
- opens a delay-enable window on a rising edge of that channel's sent pulse;
- closes the window on a rising edge of the received pulse;
- measures the sent-to-received interval in clock cycles;
- aborts the window after a programmable timeout.

It sits between the pulse generator/receiver front ends and the delay-line/readout logic of the propagation-time meter.

---
 rtl/pptm_pkg.sv | 12 +
 rtl/echo_channel.sv | 98 +++++++++
 rtl/multi_channel_echo_timer.sv | 37 +++
 tb/tb_multi_channel_echo_timer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pptm_pkg.sv
// Shared types and default sizing for the propagation-time meter echo timers.
package pptm_pkg;

  typedef enum logic {
    StIdle,
    StArmed
  } ch_state_e;

  localparam int unsigned DefCntW    = 16;
  localparam int unsigned DefTimeout = 1000;

endpackage

// File: rtl/echo_channel.sv
// One echo-timer channel: sent/recv edge detect, IDLE/ARMED window FSM,
// interval counter and last-result register.
module echo_channel
  import pptm_pkg::*;
#(
  parameter int unsigned CNT_W     = DefCntW,
  parameter int unsigned TIMEOUT   = DefTimeout,
  parameter int unsigned RETRIGGER = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sent_signal,
  input  logic             recieved_signal,
  output logic             enable_delaying,
  output logic             meas_done,
  output logic             meas_timeout,
  output logic [CNT_W-1:0] meas_cycles
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic             Retrig     = (RETRIGGER != 0);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] meas_cycles_q, meas_cycles_d;
  logic             enable_q, enable_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             sent_prev_q, recv_prev_q;

  logic             sent_edge, recv_edge;
  logic [CNT_W-1:0] cnt_inc;

  assign sent_edge = sent_signal & ~sent_prev_q;
  assign recv_edge = recieved_signal & ~recv_prev_q;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    meas_cycles_d = meas_cycles_q;
    done_d        = 1'b0;
    timeout_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A sent and recv edge landing together never opens a window.
        if (sent_edge && !recv_edge) begin
          state_d = StArmed;
          cnt_d   = '0;
        end
      end
      StArmed: begin
        cnt_d = cnt_inc;
        if (recv_edge) begin
          state_d       = StIdle;
          cnt_d         = '0;
          meas_cycles_d = cnt_inc;
          done_d        = 1'b1;
        end else if (cnt_inc == TimeoutVal) begin
          state_d   = StIdle;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else if (sent_edge && Retrig) begin
          cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    enable_d = (state_d == StArmed);
  end

  always_ff @(posedge clk) begin
    // Edge history keeps tracking through reset so a held level is not an edge.
    sent_prev_q <= sent_signal;
    recv_prev_q <= recieved_signal;
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      meas_cycles_q <= '0;
      enable_q      <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      meas_cycles_q <= meas_cycles_d;
      enable_q      <= enable_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
    end
  end

  assign enable_delaying = enable_q;
  assign meas_done       = done_q;
  assign meas_timeout    = timeout_q;
  assign meas_cycles     = meas_cycles_q;

endmodule

// File: rtl/multi_channel_echo_timer.sv
// N_CH independent echo-timer channels packed onto flat per-channel buses.
module multi_channel_echo_timer
  import pptm_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CNT_W     = DefCntW,
  parameter int unsigned TIMEOUT   = DefTimeout,
  parameter int unsigned RETRIGGER = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       sent_signal,
  input  logic [N_CH-1:0]       recieved_signal,
  output logic [N_CH-1:0]       enable_delaying,
  output logic [N_CH-1:0]       meas_done,
  output logic [N_CH-1:0]       meas_timeout,
  output logic [N_CH*CNT_W-1:0] meas_cycles
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    echo_channel #(
      .CNT_W     (CNT_W),
      .TIMEOUT   (TIMEOUT),
      .RETRIGGER (RETRIGGER)
    ) u_channel (
      .clk             (clk),
      .rst             (rst),
      .sent_signal     (sent_signal[i]),
      .recieved_signal (recieved_signal[i]),
      .enable_delaying (enable_delaying[i]),
      .meas_done       (meas_done[i]),
      .meas_timeout    (meas_timeout[i]),
      .meas_cycles     (meas_cycles[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_multi_channel_echo_timer.sv
// Scoreboard bench: stimulus pushes expected done/timeout events, a negedge
// monitor pops and checks them against three differently parameterised DUTs.
module tb_multi_channel_echo_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_bc;
  logic [3:0]  sent_a, recv_a;
  logic        sent_bc, recv_bc;
  logic [3:0]  en_a, done_a, to_a;
  logic [63:0] mc_a;
  logic        en_b, done_b, to_b, en_c, done_c, to_c;
  logic [15:0] mc_b, mc_c;

  multi_channel_echo_timer #(
    .N_CH(4), .CNT_W(16), .TIMEOUT(1000), .RETRIGGER(0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .sent_signal(sent_a), .recieved_signal(recv_a),
    .enable_delaying(en_a), .meas_done(done_a), .meas_timeout(to_a), .meas_cycles(mc_a)
  );

  multi_channel_echo_timer #(
    .N_CH(1), .CNT_W(16), .TIMEOUT(20), .RETRIGGER(0)
  ) dut_b (
    .clk(clk), .rst(rst_bc), .sent_signal(sent_bc), .recieved_signal(recv_bc),
    .enable_delaying(en_b), .meas_done(done_b), .meas_timeout(to_b), .meas_cycles(mc_b)
  );

  multi_channel_echo_timer #(
    .N_CH(1), .CNT_W(16), .TIMEOUT(20), .RETRIGGER(1)
  ) dut_c (
    .clk(clk), .rst(rst_bc), .sent_signal(sent_bc), .recieved_signal(recv_bc),
    .enable_delaying(en_c), .meas_done(done_c), .meas_timeout(to_c), .meas_cycles(mc_c)
  );

  // ecnt == n at a negedge means the cycle right after posedge n.
  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          stream;
    bit          is_to;
    logic [15:0] val;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  function automatic void push_exp(int s, bit t, logic [15:0] v, int c);
    exp_t e;
    e.stream = s;
    e.is_to  = t;
    e.val    = v;
    e.cyc    = c;
    sb.push_back(e);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic at(int n);
    while (ecnt < n - 1) @(negedge clk);
  endtask

  // Streams 0..3 = dut_a channels, 4 = dut_b, 5 = dut_c.
  always @(negedge clk) begin
    logic [5:0]  dv, tv;
    logic [15:0] mv[6];
    int          idx;
    dv = {done_c, done_b, done_a};
    tv = {to_c, to_b, to_a};
    for (int s = 0; s < 4; s++) mv[s] = mc_a[s*16 +: 16];
    mv[4] = mc_b;
    mv[5] = mc_c;
    for (int s = 0; s < 6; s++) begin
      if (dv[s] === 1'b1 || tv[s] === 1'b1) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].stream == s) begin
            idx = i;
            break;
          end
        end
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL unexpected_event stream %0d: done=%b timeout=%b cycles=%0d at cycle %0d, none required",
                   s, dv[s], tv[s], mv[s], ecnt);
        end else begin
          if (tv[s] !== sb[idx].is_to || dv[s] === tv[s] || mv[s] !== sb[idx].val ||
              ecnt != sb[idx].cyc) begin
            errors++;
            $display("FAIL event stream %0d: got done=%b timeout=%b cycles=%0d at cycle %0d, required timeout=%b cycles=%0d at cycle %0d",
                     s, dv[s], tv[s], mv[s], ecnt, sb[idx].is_to, sb[idx].val, sb[idx].cyc);
          end
          sb.delete(idx);
        end
      end
    end
  end

  task automatic prog_a();
    at(2);
    chk("rst_en_a", 64'(en_a), 0);
    chk("rst_done_a", 64'(done_a), 0);
    chk("rst_to_a", 64'(to_a), 0);
    chk("rst_mc_a", mc_a, 0);
    at(3);   rst_a = 1'b0;
    at(5);   sent_a[1] = 1'b1;
    at(7);   sent_a[1] = 1'b0;
    at(8);   recv_a[1] = 1'b1; push_exp(1, 1'b0, 16'd3, 8);
    at(10);  chk("en0_before_arm", 64'(en_a[0]), 0);
    sent_a[0] = 1'b1; recv_a[1] = 1'b0;
    at(11);  chk("en0_armed", 64'(en_a[0]), 1);
    at(12);  sent_a[0] = 1'b0;
    at(20);  sent_a[1] = 1'b1; push_exp(1, 1'b1, 16'd3, 1020);
    at(22);  sent_a[1] = 1'b0;
    at(30);  sent_a[0] = 1'b1;  // ignored, no retrigger
    at(32);  sent_a[0] = 1'b0;
    at(47);  chk("en0_last_armed", 64'(en_a[0]), 1);
    recv_a[0] = 1'b1; push_exp(0, 1'b0, 16'd37, 47);
    at(48);  chk("en0_closed", 64'(en_a[0]), 0);
    at(49);  recv_a[0] = 1'b0;
    at(50);  sent_a[2] = 1'b1;
    at(52);  sent_a[2] = 1'b0;
    at(55);  sent_a[3] = 1'b1;
    at(57);  sent_a[3] = 1'b0;
    at(70);  recv_a[3:2] = 2'b11; push_exp(2, 1'b0, 16'd20, 70); push_exp(3, 1'b0, 16'd15, 70);
    at(72);  recv_a[3:2] = 2'b00;
    at(80);  sent_a[0] = 1'b1; recv_a[0] = 1'b1;
    at(81);  chk("same_cycle_no_arm", 64'(en_a[0]), 0);
    at(82);  sent_a[0] = 1'b0; recv_a[0] = 1'b0;
    at(1020); chk("en1_before_timeout", 64'(en_a[1]), 1);
    at(1021); chk("en1_at_timeout", 64'(en_a[1]), 0);
    at(1030); sent_a[0] = 1'b1;
    at(1035); chk("en0_before_rst", 64'(en_a[0]), 1);
    rst_a = 1'b1;
    at(1036);
    chk("midrst_en_a", 64'(en_a), 0);
    chk("midrst_done_a", 64'(done_a), 0);
    chk("midrst_to_a", 64'(to_a), 0);
    chk("midrst_mc_a", mc_a, 0);
    at(1038); rst_a = 1'b0;
    at(1040); chk("no_arm_after_rst", 64'(en_a[0]), 0);
    at(1041); sent_a[0] = 1'b0;
    at(1045); sent_a[0] = 1'b1;
    at(1047); sent_a[0] = 1'b0;
    at(1050); recv_a[0] = 1'b1; push_exp(0, 1'b0, 16'd5, 1050);
    at(1052); recv_a[0] = 1'b0;
    at(1053); chk("mc0_after_rst", 64'(mc_a[15:0]), 5);
  endtask

  task automatic prog_bc();
    at(2);
    chk("rst_b", 64'({en_b, done_b, to_b, mc_b}), 0);
    chk("rst_c", 64'({en_c, done_c, to_c, mc_c}), 0);
    at(3);  rst_bc = 1'b0;
    at(5);  sent_bc = 1'b1;
    at(7);  sent_bc = 1'b0;
    at(25); recv_bc = 1'b1; push_exp(4, 1'b0, 16'd20, 25); push_exp(5, 1'b0, 16'd20, 25);
    at(27); recv_bc = 1'b0;
    at(30); sent_bc = 1'b1; push_exp(4, 1'b1, 16'd20, 50); push_exp(5, 1'b1, 16'd20, 50);
    at(32); sent_bc = 1'b0;
    at(50); chk("en_b_before_timeout", 64'(en_b), 1);
    at(51); chk("en_b_at_timeout", 64'(en_b), 0);
    at(60); sent_bc = 1'b1;
    at(62); sent_bc = 1'b0;
    at(68); sent_bc = 1'b1;
    at(70); sent_bc = 1'b0;
    at(75); recv_bc = 1'b1; push_exp(4, 1'b0, 16'd15, 75); push_exp(5, 1'b0, 16'd7, 75);
    at(77); recv_bc = 1'b0;
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", ecnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a   = 1'b1;
    rst_bc  = 1'b1;
    sent_a  = '0;
    recv_a  = '0;
    sent_bc = 1'b0;
    recv_bc = 1'b0;
    fork
      prog_a();
      prog_bc();
    join
    repeat (3) @(negedge clk);
    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL missing_event stream %0d: got nothing, required timeout=%b cycles=%0d at cycle %0d",
               sb[i].stream, sb[i].is_to, sb[i].val, sb[i].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
